// File: rtl/crc16_frame_sched.sv
// crc16_frame_sched: round-robin frame scheduler sharing one 8-bit-parallel CRC-16 engine.
// Define CRC16_FRAME_SCHED_TIMEOUT_EN to abort stalled frames (res_err_o) after TIMEOUT idle cycles.
module crc16_frame_sched #(
  parameter int NUM_REQ = 4,
  parameter int ENG_LAT = 2,
  parameter int TIMEOUT = 255,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 eng_init_o,
  output logic [7:0]           eng_data_o,
  output logic                 eng_valid_o,
  input  logic [15:0]          eng_crc_i,
  output logic                 res_valid_o,
  output logic [15:0]          res_crc_o,
  output logic [IDW-1:0]       res_id_o,
  input  logic                 res_ready_i,
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
  output logic                 res_err_o,
`endif
  output logic                 busy_o
);
  if (NUM_REQ < 2 || NUM_REQ > 8 || ENG_LAT < 1 || ENG_LAT > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("crc16_frame_sched: parameter out of range");
  end
  typedef enum logic [2:0] {IDLE, INIT, STREAM, WAIT, DONE} state_t;
  state_t         state_q, state_d;
  logic [IDW-1:0] gnt_q, gnt_d, rr_q, rr_d, pick, id_q, id_d;
  logic [IDW:0]   sum;
  logic [3:0]     wait_q, wait_d;
  logic           res_valid_q, res_valid_d;
  logic [15:0]    crc_q, crc_d;
  logic           gv, gl;
  logic [7:0]     gd;
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
  logic [7:0]     stall_q, stall_d;
  logic           err_q, err_d;
  assign res_err_o = err_q;
`endif
  assign gv          = req_valid_i[gnt_q];
  assign gl          = req_last_i[gnt_q];
  assign gd          = req_data_i[8*gnt_q +: 8];
  assign req_ready_o = (state_q == STREAM) ? NUM_REQ'(1) << gnt_q : '0;
  assign eng_valid_o = (state_q == STREAM) && gv;
  assign eng_data_o  = (state_q == STREAM) ? gd : 8'h00;
  assign eng_init_o  = (state_q == INIT);
  assign busy_o      = (state_q != IDLE);
  assign res_valid_o = res_valid_q;
  assign res_crc_o   = crc_q;
  assign res_id_o    = id_q;
  // descending scan so the entry closest to rr_q wins
  always_comb begin
    pick = '0;
    sum  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (IDW+1)'(k);
      sum = (sum >= (IDW+1)'(NUM_REQ)) ? sum - (IDW+1)'(NUM_REQ) : sum;
      if (req_valid_i[sum[IDW-1:0]]) pick = sum[IDW-1:0];
    end
  end
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    wait_d      = wait_q;
    res_valid_d = res_valid_q;
    crc_d       = crc_q;
    id_d        = id_q;
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
    stall_d     = stall_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: if (|req_valid_i) begin
        gnt_d   = pick;
        state_d = INIT;
      end
      INIT: begin
        state_d = STREAM;
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
        stall_d = '0;
`endif
      end
      STREAM: begin
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
        stall_d = gv ? 8'd0 : stall_q + 8'd1;
        if (!gv && stall_q == 8'(TIMEOUT - 1)) begin
          crc_d       = '0;
          id_d        = gnt_q;
          res_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = DONE;
        end
`endif
        if (gv && gl) begin
          wait_d  = 4'(ENG_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) begin
          crc_d       = eng_crc_i;
          id_d        = gnt_q;
          res_valid_d = 1'b1;
          state_d     = DONE;
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end
      end
      DONE: if (res_ready_i) begin
        res_valid_d = 1'b0;
        rr_d        = (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_q        <= '0;
      wait_q      <= '0;
      res_valid_q <= 1'b0;
      crc_q       <= '0;
      id_q        <= '0;
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
      stall_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      wait_q      <= wait_d;
      res_valid_q <= res_valid_d;
      crc_q       <= crc_d;
      id_q        <= id_d;
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
      stall_q     <= stall_d;
      err_q       <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_crc16_frame_sched.sv
// tb_crc16_frame_sched: directed self-checking bench for crc16_frame_sched (NUM_REQ=4, ENG_LAT=2, TIMEOUT=5).
module tb_crc16_frame_sched;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  req_valid = '0, req_last = '0, req_ready;
  logic [31:0] req_data = '0;
  logic        eng_init, eng_valid, res_valid, busy;
  logic        res_ready = 1'b1;
  logic [7:0]  eng_data;
  logic [15:0] eng_crc = '0, res_crc;
  logic [1:0]  res_id;
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
  logic        res_err;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  crc16_frame_sched #(.NUM_REQ(4), .ENG_LAT(2), .TIMEOUT(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last), .req_ready_o(req_ready),
    .eng_init_o(eng_init), .eng_data_o(eng_data), .eng_valid_o(eng_valid), .eng_crc_i(eng_crc),
    .res_valid_o(res_valid), .res_crc_o(res_crc), .res_id_o(res_id), .res_ready_i(res_ready),
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
    .res_err_o(res_err),
`endif
    .busy_o(busy)
  );
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  task automatic do_reset();
    @(negedge clk);
    rst = 1; req_valid = '0; req_last = '0; req_data = '0; eng_crc = '0; res_ready = 1;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1; req_valid = 4'hF; req_data = 32'hFFFF_FFFF; req_last = 4'hF; res_ready = 0;
    @(negedge clk); #1;
    checks++;
    if ({req_ready, eng_init, eng_valid, eng_data, res_valid, res_crc, res_id, busy} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {req_ready, eng_init, eng_valid, eng_data, res_valid, res_crc, res_id, busy});
    end
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
    checks++;
    if (res_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", res_err); end
`endif
    rst = 0; req_valid = '0; req_data = '0; req_last = '0; res_ready = 1;
  endtask
  task automatic test_single_frame();
    int inits = 0, pulses = 0;
    do_reset();
    @(negedge clk); req_valid = 4'b0001; req_data[7:0] = 8'h31; #1;
    inits += int'(eng_init); pulses += int'(eng_valid);
    checks++;
    if (req_ready !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL sf_idle: ready=%b busy=%b want 0000/0", req_ready, busy); end
    @(negedge clk); #1;
    inits += int'(eng_init); pulses += int'(eng_valid);
    checks++;
    if (eng_init !== 1'b1 || eng_valid !== 1'b0 || req_ready !== 4'b0) begin
      errors++; $display("FAIL sf_init: init=%b valid=%b ready=%b want 1/0/0000", eng_init, eng_valid, req_ready);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); req_data[7:0] = 8'(8'h31 + i); req_last[0] = (i == 8); #1;
      inits += int'(eng_init); pulses += int'(eng_valid);
      checks++;
      if (eng_valid !== 1'b1 || eng_data !== 8'(8'h31 + i) || req_ready !== 4'b0001) begin
        errors++; $display("FAIL sf_byte%0d: valid=%b data=%h ready=%b want 1/%h/0001", i, eng_valid, eng_data, req_ready, 8'(8'h31 + i));
      end
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); req_valid = '0; req_last = '0; if (c == 2) eng_crc = 16'hBEEF; #1;
      inits += int'(eng_init); pulses += int'(eng_valid);
      checks++;
      if (res_valid !== (c == 3)) begin errors++; $display("FAIL sf_latency_c%0d: res_valid=%b want %b", c, res_valid, c == 3); end
    end
    checks++;
    if (res_crc !== 16'hBEEF || res_id !== 2'd0) begin errors++; $display("FAIL sf_result: crc=%h id=%0d want beef/0", res_crc, res_id); end
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
    checks++;
    if (res_err !== 1'b0) begin errors++; $display("FAIL sf_err: got %b want 0", res_err); end
`endif
    checks++;
    if (inits != 1 || pulses != 9) begin errors++; $display("FAIL sf_counts: inits=%0d pulses=%0d want 1/9", inits, pulses); end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL sf_release: busy=%b res_valid=%b want 0/0", busy, res_valid); end
  endtask
  task automatic test_round_robin();
    do_reset();
    for (int g = 0; g < 4; g++) begin
      @(negedge clk); req_valid = 4'hF; req_last = '0; req_data = 32'h41_31_21_11; eng_crc = '0; #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle%0d: busy=%b want 0", g, busy); end
      @(negedge clk); #1;
      @(negedge clk); #1;
      checks++;
      if (req_ready !== 4'(1 << g) || eng_data !== 8'(8'h11 + 8'h10 * g)) begin
        errors++; $display("FAIL rr_grant%0d: ready=%b data=%h want %b/%h", g, req_ready, eng_data, 4'(1 << g), 8'(8'h11 + 8'h10 * g));
      end
      @(negedge clk); req_data = 32'h42_32_22_12; req_last = 4'hF; #1;
      checks++;
      if (eng_valid !== 1'b1 || eng_data !== 8'(8'h12 + 8'h10 * g)) begin
        errors++; $display("FAIL rr_byte2_%0d: valid=%b data=%h want 1/%h", g, eng_valid, eng_data, 8'(8'h12 + 8'h10 * g));
      end
      @(negedge clk); req_valid = '0; req_last = '0; #1;
      @(negedge clk); eng_crc = 16'(16'hA000 + g); #1;
      @(negedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_id !== 2'(g) || res_crc !== 16'(16'hA000 + g)) begin
        errors++; $display("FAIL rr_result%0d: valid=%b id=%0d crc=%h want 1/%0d/%h", g, res_valid, res_id, res_crc, g, 16'(16'hA000 + g));
      end
    end
    @(negedge clk); req_valid = 4'b1010; req_data = 32'h77_00_66_00; #1;
    @(negedge clk); #1;
    @(negedge clk); req_last = 4'hF; #1;
    checks++;
    if (req_ready !== 4'b0010 || eng_data !== 8'h66) begin errors++; $display("FAIL rr_wrap: ready=%b data=%h want 0010/66", req_ready, eng_data); end
    @(negedge clk); req_valid = '0; req_last = '0; #1;
    @(negedge clk); eng_crc = 16'h5151; #1;
    @(negedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || res_crc !== 16'h5151) begin
      errors++; $display("FAIL rr_wrap_result: valid=%b id=%0d crc=%h want 1/1/5151", res_valid, res_id, res_crc);
    end
  endtask
  task automatic test_back_pressure();
    do_reset();
    @(negedge clk); req_valid = 4'b0100; req_data = 32'h00_5A_00_00; req_last = 4'b0100; res_ready = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (eng_valid !== 1'b1 || eng_data !== 8'h5A || req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_byte: valid=%b data=%h ready=%b want 1/5a/0100", eng_valid, eng_data, req_ready);
    end
    @(negedge clk); req_valid = 4'hF; #1;
    checks++;
    if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_wait_ready: ready=%b want 0000", req_ready); end
    @(negedge clk); eng_crc = 16'h1234; #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); eng_crc = 16'hFFFF; #1;
      checks++;
      if (res_valid !== 1'b1 || res_crc !== 16'h1234 || res_id !== 2'd2 || req_ready !== 4'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d: valid=%b crc=%h id=%0d ready=%b busy=%b want 1/1234/2/0000/1", i, res_valid, res_crc, res_id, req_ready, busy);
      end
    end
    @(negedge clk); res_ready = 1; #1;
    checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_release: res_valid=%b want 1", res_valid); end
    @(negedge clk); req_valid = '0; req_last = '0; #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: busy=%b res_valid=%b want 0/0", busy, res_valid); end
  endtask
  task automatic test_gappy_stream();
    int pulses = 0;
    do_reset();
    @(negedge clk); req_valid = 4'b0100; req_data = '0; #1;
    @(negedge clk); req_valid = 4'b0101; #1;
    checks++;
    if (req_ready !== 4'b0 || eng_init !== 1'b1) begin errors++; $display("FAIL gap_init: ready=%b init=%b want 0000/1", req_ready, eng_init); end
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      req_valid = {1'b0, k % 4 == 0, 1'b0, 1'b1};
      req_data[23:16] = 8'(8'hA0 + k / 4); req_data[7:0] = 8'h77; req_last[2] = (k == 12); #1;
      pulses += int'(eng_valid);
      checks++;
      if (req_ready !== 4'b0100 || eng_valid !== (k % 4 == 0) || (eng_valid === 1'b1 && eng_data !== 8'(8'hA0 + k / 4))) begin
        errors++; $display("FAIL gap_cycle%0d: ready=%b valid=%b data=%h want 0100/%b/%h", k, req_ready, eng_valid, eng_data, k % 4 == 0, 8'(8'hA0 + k / 4));
      end
    end
    checks++;
    if (pulses != 4) begin errors++; $display("FAIL gap_pulses: got %0d want 4", pulses); end
    @(negedge clk); req_valid = 4'b0001; req_last = '0; eng_crc = 16'h0F0F; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd2 || res_crc !== 16'h0F0F) begin
      errors++; $display("FAIL gap_result: valid=%b id=%0d crc=%h want 1/2/0f0f", res_valid, res_id, res_crc);
    end
  endtask
  task automatic test_reset_mid_stream();
    do_reset();
    @(negedge clk); req_valid = 4'b0010; req_last = 4'b0010; req_data = 32'h0000_3300; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); req_valid = '0; req_last = '0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1) begin errors++; $display("FAIL rm_first: valid=%b id=%0d want 1/1", res_valid, res_id); end
    @(negedge clk); req_valid = 4'b1000; req_data[31:24] = 8'hC1; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 4'b1000 || eng_data !== 8'hC1) begin errors++; $display("FAIL rm_stream: ready=%b data=%h want 1000/c1", req_ready, eng_data); end
    @(negedge clk); req_data[31:24] = 8'hC2; #1;
    @(negedge clk); rst = 1; req_data[31:24] = 8'hC3; #1;
    @(negedge clk); rst = 0; req_valid = 4'b1010; #1;
    checks++;
    if ({req_ready, eng_init, eng_valid, eng_data, res_valid, res_crc, res_id, busy} !== 34'h0) begin
      errors++;
      $display("FAIL rm_outputs: got %h want 0", {req_ready, eng_init, eng_valid, eng_data, res_valid, res_crc, res_id, busy});
    end
    @(negedge clk); #1;
    checks++;
    if (eng_init !== 1'b1 || eng_valid !== 1'b0) begin errors++; $display("FAIL rm_init: init=%b valid=%b want 1/0", eng_init, eng_valid); end
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_grant: ready=%b want 0010", req_ready); end
  endtask
  task automatic test_stall();
    do_reset();
    @(negedge clk); req_valid = 4'b0010; req_data = 32'h0000_5500; req_last = '0; eng_crc = 16'hDEAD; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (eng_valid !== 1'b1 || eng_data !== 8'h55) begin errors++; $display("FAIL st_byte: valid=%b data=%h want 1/55", eng_valid, eng_data); end
    for (int s = 1; s <= 5; s++) begin
      @(negedge clk); req_valid = '0; #1;
      checks++;
      if (res_valid !== 1'b0 || req_ready !== 4'b0010) begin
        errors++; $display("FAIL st_stall%0d: res_valid=%b ready=%b want 0/0010", s, res_valid, req_ready);
      end
    end
    @(negedge clk); #1;
`ifdef CRC16_FRAME_SCHED_TIMEOUT_EN
    checks++;
    if (res_valid !== 1'b1 || res_err !== 1'b1 || res_crc !== 16'h0000 || res_id !== 2'd1 || req_ready !== 4'b0) begin
      errors++; $display("FAIL st_abort: valid=%b err=%b crc=%h id=%0d ready=%b want 1/1/0000/1/0000", res_valid, res_err, res_crc, res_id, req_ready);
    end
`else
    for (int s = 0; s < 10; s++) begin
      @(negedge clk); #1;
      checks++;
      if (res_valid !== 1'b0 || req_ready !== 4'b0010 || busy !== 1'b1) begin
        errors++; $display("FAIL st_hold%0d: res_valid=%b ready=%b busy=%b want 0/0010/1", s, res_valid, req_ready, busy);
      end
    end
`endif
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_back_pressure();
    test_gappy_stream();
    test_reset_mid_stream();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
